// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl -- 8-entry in-order reorder buffer commit controller.
//
// Instructions are allocated in program order at the tail and complete out of
// order through the writeback port. The head entry retires once it is marked
// done, so at most one entry retires per cycle. Retirement drives a registered
// register-file write port.
//
// Ports
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low
//   alloc_req           issue requests one entry
//   alloc_ok / alloc_tag  combinational: room available / tag handed out
//   wb_valid/tag/data/dest/we  completion from writeback
//   flush               synchronous squash of every entry
//   retire, rf_we, rf_addr, rf_data  registered retirement outputs
//   count, empty        occupancy (registered) and its zero flag

// One ROB slot: alloc/done flags plus the completion payload.
module rob_entry (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        set_alloc,
  input  logic        clr_alloc,
  input  logic        wb_wr,
  input  logic        wb_we,
  input  logic [2:0]  wb_dest,
  input  logic [15:0] wb_data,
  output logic        alloc,
  output logic        done,
  output logic        we,
  output logic [2:0]  dest,
  output logic [15:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc <= 1'b0;
      done  <= 1'b0;
      we    <= 1'b0;
      dest  <= '0;
      data  <= '0;
    end else if (flush) begin
      alloc <= 1'b0;
      done  <= 1'b0;
    end else begin
      // set_alloc and clr_alloc never target the same slot: a slot being
      // committed is allocated, so it cannot be the free slot at the tail.
      if (set_alloc) begin
        alloc <= 1'b1;
        done  <= 1'b0;
      end
      if (clr_alloc) alloc <= 1'b0;
      if (wb_wr) begin
        done <= 1'b1;
        we   <= wb_we;
        dest <= wb_dest;
        data <= wb_data;
      end
    end
  end

endmodule

module rob_commit_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc_req,
  output logic        alloc_ok,
  output logic [2:0]  alloc_tag,
  input  logic        wb_valid,
  input  logic [2:0]  wb_tag,
  input  logic [15:0] wb_data,
  input  logic [2:0]  wb_dest,
  input  logic        wb_we,
  input  logic        flush,
  output logic        retire,
  output logic        rf_we,
  output logic [2:0]  rf_addr,
  output logic [15:0] rf_data,
  output logic [3:0]  count,
  output logic        empty
);

  localparam int DEPTH = 8;

  logic [2:0] head_q, tail_q;

  logic [DEPTH-1:0]       ent_alloc, ent_done, ent_we;
  logic [DEPTH-1:0][2:0]  ent_dest;
  logic [DEPTH-1:0][15:0] ent_data;

  logic do_alloc, do_commit, wb_hit;

  assign alloc_ok  = (count < 4'd8);
  assign alloc_tag = tail_q;
  assign empty     = (count == 4'd0);

  // Every decision below looks only at pre-edge entry state, so a completion
  // to the head this cycle commits next cycle, and a completion to the slot
  // being allocated this cycle is dropped.
  assign do_alloc  = alloc_req && alloc_ok;
  assign do_commit = ent_alloc[head_q] && ent_done[head_q];
  assign wb_hit    = wb_valid && ent_alloc[wb_tag] && !ent_done[wb_tag];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rob_entry u_ent (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .set_alloc (do_alloc  && (tail_q == 3'(i))),
      .clr_alloc (do_commit && (head_q == 3'(i))),
      .wb_wr     (wb_hit    && (wb_tag == 3'(i))),
      .wb_we     (wb_we),
      .wb_dest   (wb_dest),
      .wb_data   (wb_data),
      .alloc     (ent_alloc[i]),
      .done      (ent_done[i]),
      .we        (ent_we[i]),
      .dest      (ent_dest[i]),
      .data      (ent_data[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count   <= '0;
      retire  <= 1'b0;
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count   <= '0;
      retire  <= 1'b0;
      rf_we   <= 1'b0;
    end else begin
      if (do_alloc) tail_q <= tail_q + 3'd1;
      if (do_commit) begin
        head_q  <= head_q + 3'd1;
        retire  <= 1'b1;
        rf_we   <= ent_we[head_q];
        rf_addr <= ent_dest[head_q];
        rf_data <= ent_data[head_q];
      end else begin
        // rf_addr/rf_data hold their last retired values.
        retire <= 1'b0;
        rf_we  <= 1'b0;
      end
      count <= count + {3'b0, do_alloc} - {3'b0, do_commit};
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alloc_req = 1'b0;
  logic        alloc_ok;
  logic [2:0]  alloc_tag;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_tag = '0;
  logic [15:0] wb_data = '0;
  logic [2:0]  wb_dest = '0;
  logic        wb_we = 1'b0;
  logic        flush = 1'b0;
  logic        retire, rf_we;
  logic [2:0]  rf_addr;
  logic [15:0] rf_data;
  logic [3:0]  count;
  logic        empty;

  typedef struct packed {
    logic        we;
    logic [2:0]  dest;
    logic [15:0] data;
  } ret_t;

  ret_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  rob_commit_ctrl dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ok(alloc_ok),
    .alloc_tag(alloc_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_data(wb_data), .wb_dest(wb_dest), .wb_we(wb_we), .flush(flush),
    .retire(retire), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Scoreboard: every retirement must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && retire) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_retire: got we=%0b addr=%0d data=%h, required no retire",
                 rf_we, rf_addr, rf_data);
      end else begin
        ret_t e;
        e = exp_q.pop_front();
        if ({rf_we, rf_addr, rf_data} !== {e.we, e.dest, e.data}) begin
          errors++;
          $display("FAIL sb_retire: got we=%0b addr=%0d data=%h, required we=%0b addr=%0d data=%h",
                   rf_we, rf_addr, rf_data, e.we, e.dest, e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic [2:0] tag, input logic [15:0] d,
                          input logic [2:0] dst, input logic we);
    wb_valid = 1'b1; wb_tag = tag; wb_data = d; wb_dest = dst; wb_we = we;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (retire !== 1'b0)   begin errors++; $display("FAIL rst_retire: got %0b, required 0", retire); end
    checks++; if (rf_we !== 1'b0)    begin errors++; $display("FAIL rst_rf_we: got %0b, required 0", rf_we); end
    checks++; if (rf_addr !== 3'd0)  begin errors++; $display("FAIL rst_rf_addr: got %0d, required 0", rf_addr); end
    checks++; if (rf_data !== 16'h0) begin errors++; $display("FAIL rst_rf_data: got %h, required 0", rf_data); end
    checks++; if (count !== 4'd0)    begin errors++; $display("FAIL rst_count: got %0d, required 0", count); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty: got %0b, required 1", empty); end
    checks++; if (alloc_ok !== 1'b1) begin errors++; $display("FAIL rst_alloc_ok: got %0b, required 1", alloc_ok); end
    checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL rst_alloc_tag: got %0d, required 0", alloc_tag); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Allocate tags 0,1,2; complete tag 0 and see it retire two edges later.
  task automatic test_basic;
    alloc_req = 1'b1;
    repeat (3) tick();
    alloc_req = 1'b0;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count3: got %0d, required 3", count); end
    checks++; if (alloc_tag !== 3'd3) begin errors++; $display("FAIL basic_tag: got %0d, required 3", alloc_tag); end
    drive_wb(3'd0, 16'h1234, 3'd5, 1'b1);
    exp_q.push_back('{1'b1, 3'd5, 16'h1234});
    tick();
    wb_valid = 1'b0;
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL basic_no_bypass: got %0b, required 0", retire); end
    tick();
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL basic_retire: got %0b, required 1", retire); end
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL basic_rf_we: got %0b, required 1", rf_we); end
    checks++; if (rf_addr !== 3'd5) begin errors++; $display("FAIL basic_rf_addr: got %0d, required 5", rf_addr); end
    checks++; if (rf_data !== 16'h1234) begin errors++; $display("FAIL basic_rf_data: got %h, required 1234", rf_data); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL basic_count2: got %0d, required 2", count); end
  endtask

  // we=0 completion, then an ignored completion to an unallocated tag.
  task automatic test_no_we;
    drive_wb(3'd1, 16'hBEEF, 3'd3, 1'b0);
    exp_q.push_back('{1'b0, 3'd3, 16'hBEEF});
    tick();
    wb_valid = 1'b0;
    tick();
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL nowe_retire: got %0b, required 1", retire); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL nowe_rf_we: got %0b, required 0", rf_we); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL nowe_count: got %0d, required 1", count); end
    drive_wb(3'd5, 16'h5555, 3'd1, 1'b1);
    tick();
    wb_valid = 1'b0;
    tick();
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL unalloc_retire: got %0b, required 0", retire); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL unalloc_count: got %0d, required 1", count); end
    drive_wb(3'd2, 16'h0022, 3'd2, 1'b1);
    exp_q.push_back('{1'b1, 3'd2, 16'h0022});
    tick();
    wb_valid = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b, required 1", empty); end
  endtask

  // Tags 3,4,5 complete in reverse order (with a duplicate to 5) and retire 3,4,5.
  task automatic test_out_of_order;
    checks++; if (alloc_tag !== 3'd3) begin errors++; $display("FAIL ooo_first_tag: got %0d, required 3", alloc_tag); end
    alloc_req = 1'b1;
    repeat (3) tick();
    alloc_req = 1'b0;
    exp_q.push_back('{1'b1, 3'd3, 16'h00A3});
    exp_q.push_back('{1'b1, 3'd4, 16'h00A4});
    exp_q.push_back('{1'b1, 3'd5, 16'h00A5});
    drive_wb(3'd5, 16'h00A5, 3'd5, 1'b1); tick();
    drive_wb(3'd5, 16'hFFFF, 3'd7, 1'b0); tick();
    drive_wb(3'd4, 16'h00A4, 3'd4, 1'b1); tick();
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL ooo_hold: got %0b, required 0", retire); end
    drive_wb(3'd3, 16'h00A3, 3'd3, 1'b1); tick();
    wb_valid = 1'b0;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL ooo_count3: got %0d, required 3", count); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (retire !== 1'b1 || rf_addr !== 3'(3 + i) || count !== 4'(2 - i)) begin
        errors++;
        $display("FAIL ooo_order%0d: got retire=%0b addr=%0d count=%0d, required 1/%0d/%0d",
                 i, retire, rf_addr, count, 3 + i, 2 - i);
      end
    end
    checks++; if (rf_data !== 16'h00A5) begin errors++; $display("FAIL ooo_dup_ignored: got %h, required 00a5", rf_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ooo_empty: got %0b, required 1", empty); end
  endtask

  // Flush beats alloc, completion and a committable head in the same cycle.
  task automatic test_flush;
    alloc_req = 1'b1;
    repeat (2) tick();
    alloc_req = 1'b0;
    drive_wb(3'd6, 16'h6666, 3'd6, 1'b1); tick();
    flush = 1'b1; alloc_req = 1'b1;
    drive_wb(3'd7, 16'h7777, 3'd7, 1'b1);
    tick();
    flush = 1'b0; alloc_req = 1'b0; wb_valid = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d, required 0", count); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL flush_retire: got %0b, required 0", retire); end
    checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL flush_tag: got %0d, required 0", alloc_tag); end
    tick();
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL flush_after: got %0b, required 0", retire); end
  endtask

  // Fill all 8 (same-cycle completion to tag 0 ignored), then retire while full.
  task automatic test_full;
    alloc_req = 1'b1;
    drive_wb(3'd0, 16'hDEAD, 3'd1, 1'b1);
    tick();
    wb_valid = 1'b0;
    repeat (7) tick();
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d, required 8", count); end
    checks++; if (alloc_ok !== 1'b0) begin errors++; $display("FAIL full_alloc_ok: got %0b, required 0", alloc_ok); end
    tick();
    checks++; if (count !== 4'd8 || retire !== 1'b0) begin errors++; $display("FAIL full_ignore: got count=%0d retire=%0b, required 8/0", count, retire); end
    drive_wb(3'd0, 16'h0600, 3'd6, 1'b1);
    exp_q.push_back('{1'b1, 3'd6, 16'h0600});
    tick();
    wb_valid = 1'b0;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_done_count: got %0d, required 8", count); end
    tick();
    alloc_req = 1'b0;
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL full_retire: got %0b, required 1", retire); end
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_no_alloc: got %0d, required 7", count); end
    checks++; if (alloc_ok !== 1'b1 || alloc_tag !== 3'd0) begin errors++; $display("FAIL full_wrap: got ok=%0b tag=%0d, required 1/0", alloc_ok, alloc_tag); end
  endtask

  // Asynchronous reset mid-sequence discards a done head entry.
  task automatic test_reset_mid;
    drive_wb(3'd1, 16'h1111, 3'd1, 1'b1);
    tick();
    wb_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL rmid_count: got %0d/%0b, required 0/1", count, empty); end
    checks++; if (rf_addr !== 3'd0 || rf_data !== 16'h0) begin errors++; $display("FAIL rmid_rf: got %0d/%h, required 0/0000", rf_addr, rf_data); end
    checks++; if (retire !== 1'b0 || rf_we !== 1'b0 || alloc_ok !== 1'b1 || alloc_tag !== 3'd0) begin
      errors++; $display("FAIL rmid_ctl: got retire=%0b rf_we=%0b ok=%0b tag=%0d, required 0/0/1/0", retire, rf_we, alloc_ok, alloc_tag);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (retire !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL rmid_release: got retire=%0b count=%0d, required 0/0", retire, count); end
    tick();
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL rmid_discard: got %0b, required 0", retire); end
  endtask

  // Pipelined alloc/complete/commit; simultaneous alloc+commit keeps count.
  task automatic test_back_to_back;
    for (int k = 0; k < 6; k++) begin
      alloc_req = (k < 4);
      if (k >= 1 && k <= 4) begin
        drive_wb(3'(k - 1), 16'(16'hB000 + k), 3'(k), 1'b1);
        exp_q.push_back('{1'b1, 3'(k), 16'(16'hB000 + k)});
      end else begin
        wb_valid = 1'b0;
      end
      tick();
      if (k == 2 || k == 3) begin
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d, required 2", k, count); end
      end
      if (k >= 2) begin
        checks++; if (retire !== 1'b1) begin errors++; $display("FAIL b2b_retire%0d: got %0b, required 1", k, retire); end
      end
    end
    alloc_req = 1'b0; wb_valid = 1'b0;
    tick();
    checks++; if (empty !== 1'b1 || retire !== 1'b0) begin errors++; $display("FAIL b2b_end: got empty=%0b retire=%0b, required 1/0", empty, retire); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_we();
    test_out_of_order();
    test_flush();
    test_full();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
